// File: rtl/seg7_display_driver.sv
// Four-digit common-anode MM.SS scanner. The digits are refreshed from a snapshot
// of minutes/seconds taken once per frame. In adjust mode the selected field blinks.
module seg7_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_idx;
  logic [5:0]    r_snap_m;
  logic [5:0]    r_snap_s;
  logic [BW-1:0] r_bcnt;
  logic          r_bphase;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;

  logic          w_tick;
  logic [5:0]    w_field;
  logic          w_dash;
  logic [3:0]    w_digit;
  logic [6:0]    w_cath;
  logic          w_blank;
  logic [3:0]    w_an_nxt;
  logic [7:0]    w_seg_nxt;

  assign w_tick = (r_rcnt == R_LAST);

  // Slots 0/1 show seconds, slots 2/3 show minutes; odd slots are the tens digit.
  assign w_field = r_idx[1] ? r_snap_m : r_snap_s;
  assign w_dash  = (w_field > 6'd59);
  assign w_digit = r_idx[0] ? 4'(w_field / 6'd10) : 4'(w_field % 6'd10);

  always_comb begin
    w_cath = 7'b0111111;
    if (!w_dash) begin
      case (w_digit)
        4'd0:    w_cath = 7'b1000000;
        4'd1:    w_cath = 7'b1111001;
        4'd2:    w_cath = 7'b0100100;
        4'd3:    w_cath = 7'b0110000;
        4'd4:    w_cath = 7'b0011001;
        4'd5:    w_cath = 7'b0010010;
        4'd6:    w_cath = 7'b0000010;
        4'd7:    w_cath = 7'b1111000;
        4'd8:    w_cath = 7'b0000000;
        4'd9:    w_cath = 7'b0010000;
        default: w_cath = 7'b0111111;
      endcase
    end
  end

  // sel=1 blinks the seconds slots (idx[1]=0), sel=0 the minutes slots (idx[1]=1).
  assign w_blank   = adj && r_bphase && (r_idx[1] != sel);
  assign w_an_nxt  = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
  assign w_seg_nxt = w_blank ? 8'hFF : {(r_idx != 2'd2), w_cath};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rcnt   <= '0;
      r_idx    <= 2'd0;
      r_snap_m <= 6'd0;
      r_snap_s <= 6'd0;
    end else begin
      r_rcnt <= w_tick ? '0 : r_rcnt + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_snap_m <= minutes;
          r_snap_s <= seconds;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
    end else if (!adj) begin
      r_bcnt   <= '0;
      r_bphase <= 1'b0;
    end else if (r_bcnt == B_LAST) begin
      r_bcnt   <= '0;
      r_bphase <= ~r_bphase;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_an  <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: doc/seg7_display_driver.md
# seg7_display_driver

Downstream consumer of the stopwatch counter's `minutes`/`seconds` values. Drives a 4-digit, common-anode, time-multiplexed seven-segment display in MM.SS format. Converts binary to BCD, scans the digits at a parameterised refresh rate, and latches a tear-free snapshot once per frame. When adjust mode is on, it blinks the selected field.

## Interface
Parameters:
- `REFRESH_DIV`, 100000: clk cycles per digit slot (1 kHz digit rate / 250 Hz frame at 100 MHz)
- `BLINK_DIV`, 25000000: clk cycles per blink half-period (2 Hz blink at 100 MHz)

Ports:
- `clk`  in  1  100 MHz system clock, sole clock
- `arst_n`  in  1  asynchronous, active-low reset
- `minutes`  in  6  binary minutes from counter, legal 0–59
- `seconds`  in  6  binary seconds from counter, legal 0–59
- `adj`  in  1  adjust mode active (debounced switch)
- `sel`  in  1  adjust field select: 0 = minutes, 1 = seconds
- `an`  out  4  anode enables, active-low, an[0] = rightmost digit
- `seg`  out  8  active-low cathodes, seg[7] = dp, seg[6:0] = {g,f,e,d,c,b,a}

## Operation
- Refresh counter `rcnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (rcnt == REFRESH_DIV-1).
- Digit index `idx` (2 bits) increments on `tick` and wraps 3→0. Mapping: 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens.
- Snapshot registers `snap_m`/`snap_s` load `minutes`/`seconds` on `tick` when idx==3, i.e. at the frame boundary. Input changes mid-frame never appear until the next frame.
- BCD conversion: tens = v/10, ones = v%10. Any value 60–63 displays as a dash on both digits of that field.
- Segment codes (g..a, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111
- dp (seg[7]) = 0 only when idx==2; otherwise 1.
- Blink counter `bcnt` counts 0..BLINK_DIV-1. At terminal count it wraps and toggles `bphase`.
  - While adj==0, `bcnt` and `bphase` are held at 0 synchronously.
- Blanking: when adj==1 and bphase==1, slots of the selected field (idx 0/1 if sel==1, idx 2/3 if sel==0) drive an=1111 and seg=8'hFF. The other field displays normally. `adj`/`sel` are used live, not snapshotted.
- Otherwise `an` has a single 0 at bit `idx`.

## Timing
- Reset (arst_n low, asynchronous): an=4'b1111, seg=8'hFF, rcnt=0, idx=0, bcnt=0, bphase=0, snap_m=0, snap_s=0.
- `an`/`seg` are registered and reflect `idx`/snapshot/blink state with 1-cycle latency.
- First clk edge after reset release: an=1110, seg shows digit '0' of snapshot 0.
- Each digit is held for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- The snapshot taken on `tick` at idx==3 is visible from the idx==0 slot, 1 cycle after the tick.
- adj 1→0: blanking stops on the next registered output, within 1 cycle.
- adj 0→1: first BLINK_DIV cycles are visible (bphase=0), then blanked.
- `tick` and blink terminal count in the same cycle are independent; both take effect.
- Reset asserted mid-scan forces reset values immediately. The scan restarts at idx=0 on release.

## Test plan
Use REFRESH_DIV=4, BLINK_DIV=32.
1. Reset, then minutes=12, seconds=34, adj=0. After the first frame boundary, slots cycle:
   - an=1110, seg=8'b10011001
   - an=1101, seg=8'b10110000
   - an=1011, seg=8'b00100100
   - an=0111, seg=8'b11111001
   - each held 4 cycles
2. Tear-freedom: with 12:34 displayed, change seconds to 35 during the idx==1 slot. Remaining slots of that frame still show 12.34; the next frame's idx==0 slot shows '5' (seg=8'b10010010).
3. Out of range: minutes=60, seconds=7.
   - idx3 seg=8'b10111111
   - idx2 seg=8'b00111111
   - idx1 shows '0', idx0 shows '7'
4. Blink: adj=1, sel=1.
   - First 32 cycles: all four digits scan normally.
   - Next 32 cycles: idx0/idx1 slots give an=1111, seg=FF; minutes slots unchanged.
   - Drop adj: full display on the next cycle, bphase=0.
5. Reset mid-scan: pull arst_n low during the idx==2 slot. an=1111 and seg=FF with no clock edge. On release, the first slot is an=1110.
6. Wrap: seconds 59→0 and minutes 59→0 across frames. Display goes 59.59 → 00.00 with no intermediate mixed frame.
